// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_VEC, OWN_MEM, OWN_IF} owner_e;
    typedef enum logic {ST_IDLE, ST_ACCESS} state_e;

    localparam int unsigned VEC_RESET = 0;
    localparam int unsigned VEC_INTR  = 1;

    // Bit positions of the one-hot pick / grant / valid vectors
    localparam int unsigned PICK_VEC = 0;
    localparam int unsigned PICK_MEM = 1;
    localparam int unsigned PICK_IF  = 2;

    function automatic owner_e onehot_to_owner(input logic [2:0] oh);
        owner_e own;
        own = OWN_NONE;
        if (oh[PICK_VEC])      own = OWN_VEC;
        else if (oh[PICK_MEM]) own = OWN_MEM;
        else if (oh[PICK_IF])  own = OWN_IF;
        return own;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority requester selector: vec > mem > if, with fetch promoted above
// mem while the starve override is set.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_vec_req,
    input  logic       i_mem_req,
    input  logic       i_if_req,
    input  logic       i_starve,
    output logic [2:0] o_pick
);

    always_comb begin
        o_pick = '0;
        if (i_vec_req) begin
            o_pick[PICK_VEC] = 1'b1;
        end else if (i_if_req && (i_starve || !i_mem_req)) begin
            o_pick[PICK_IF] = 1'b1;
        end else if (i_mem_req) begin
            o_pick[PICK_MEM] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter/sequencer for vector, memory-stage and fetch requesters.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW           = 12,
    parameter int unsigned DW           = 16,
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_vec_req,
    input  logic          i_vec_sel,
    input  logic          i_mem_req,
    input  logic          i_mem_we,
    input  logic [AW-1:0] i_mem_addr,
    input  logic [DW-1:0] i_mem_wdata,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    input  logic          i_if_flush,
    output logic          o_vec_gnt,
    output logic          o_mem_gnt,
    output logic          o_if_gnt,
    output logic          o_vec_valid,
    output logic          o_mem_valid,
    output logic          o_if_valid,
    output logic [DW-1:0] o_rd_data,
    output logic          o_mem_stall,
    output logic          o_if_stall,
    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);

    state_e        r_state;
    owner_e        r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [2:0]    r_cnt;
    logic          r_drop;
    logic [DW-1:0] r_rd_data;
    logic [2:0]    r_valid;

    logic [2:0]    w_pick;
    logic [2:0]    w_gnt;
    logic          w_idle;
    logic          w_starve;
    logic          w_we;
    logic          w_last;
    logic          w_flush_hit;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    mem_arb_pick u_pick (
        .i_vec_req (i_vec_req),
        .i_mem_req (i_mem_req),
        .i_if_req  (i_if_req),
        .i_starve  (w_starve),
        .o_pick    (w_pick)
    );

    // Gating with i_reset keeps every combinational output low while reset is held
    assign w_idle      = (r_state == ST_IDLE) && i_reset;
    assign w_gnt       = w_idle ? w_pick : 3'b000;
    assign w_we        = w_pick[PICK_MEM] & i_mem_we;
    assign w_wdata     = w_pick[PICK_MEM] ? i_mem_wdata : '0;
    assign w_addr      = w_pick[PICK_VEC] ? (i_vec_sel ? AW'(VEC_INTR) : AW'(VEC_RESET))
                       : w_pick[PICK_MEM] ? i_mem_addr : i_if_addr;
    assign w_last      = (r_cnt == 3'(WAIT_CYCLES - 1));
    assign w_flush_hit = (r_owner == OWN_IF) && i_if_flush;

    assign o_vec_gnt   = w_gnt[PICK_VEC];
    assign o_mem_gnt   = w_gnt[PICK_MEM];
    assign o_if_gnt    = w_gnt[PICK_IF];
    assign o_mem_stall = i_reset & i_mem_req & ~w_gnt[PICK_MEM];
    assign o_if_stall  = i_reset & i_if_req & ~w_gnt[PICK_IF];
    assign o_vec_valid = r_valid[PICK_VEC];
    assign o_mem_valid = r_valid[PICK_MEM];
    assign o_if_valid  = r_valid[PICK_IF];
    assign o_rd_data   = r_rd_data;

    always_comb begin
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (r_state == ST_ACCESS) begin
            o_ram_en    = 1'b1;
            o_ram_we    = r_we;
            o_ram_addr  = r_addr;
            o_ram_wdata = r_wdata;
        end else if (w_idle && (|w_pick)) begin
            o_ram_en    = 1'b1;
            o_ram_we    = w_we;
            o_ram_addr  = w_addr;
            o_ram_wdata = w_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_NONE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_drop    <= 1'b0;
            r_rd_data <= '0;
            r_valid   <= '0;
        end else begin
            r_valid <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_pick) begin
                        r_state <= ST_ACCESS;
                        r_owner <= onehot_to_owner(w_pick);
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_cnt   <= '0;
                        r_drop  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_flush_hit) r_drop <= 1'b1;
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_owner <= OWN_NONE;
                        if (!r_we) r_rd_data <= i_ram_rdata;
                        unique case (r_owner)
                            OWN_VEC: r_valid[PICK_VEC] <= 1'b1;
                            OWN_MEM: r_valid[PICK_MEM] <= 1'b1;
                            OWN_IF:  r_valid[PICK_IF]  <= ~(r_drop | w_flush_hit);
                            default: r_valid <= '0;
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [7:0] r_starve_cnt;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_starve_cnt <= '0;
        end else if (!i_if_req || w_gnt[PICK_IF]) begin
            r_starve_cnt <= '0;
        end else if (w_gnt[PICK_MEM] && (r_starve_cnt < 8'(STARVE_LIMIT))) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    assign w_starve = (r_starve_cnt >= 8'(STARVE_LIMIT));
`else
    assign w_starve = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: transaction model predicts grants and
// completions; a separate monitor checks valids and read data.
module tb_mem_port_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int W   = 3;
    localparam int LIM = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vec_req = 1'b0, vec_sel = 1'b0;
    logic          mem_req = 1'b0, mem_we = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic          vec_gnt, mem_gnt, if_gnt, vec_valid, mem_valid, if_valid;
    logic [DW-1:0] rd_data;
    logic          mem_stall, if_stall, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .WAIT_CYCLES  (W),
        .STARVE_LIMIT (LIM)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_vec_req   (vec_req),
        .i_vec_sel   (vec_sel),
        .i_mem_req   (mem_req),
        .i_mem_we    (mem_we),
        .i_mem_addr  (mem_addr),
        .i_mem_wdata (mem_wdata),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .i_if_flush  (if_flush),
        .o_vec_gnt   (vec_gnt),
        .o_mem_gnt   (mem_gnt),
        .o_if_gnt    (if_gnt),
        .o_vec_valid (vec_valid),
        .o_mem_valid (mem_valid),
        .o_if_valid  (if_valid),
        .o_rd_data   (rd_data),
        .o_mem_stall (mem_stall),
        .o_if_stall  (if_stall),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    logic [DW-1:0] ram    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram[ram_addr];
        end
    end

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        bit            we;
        bit            drop;
        int            due;
    } exp_t;

    exp_t          q[$];
    int            nvec = 0, nbad = 0, cyc = 0;
    logic [DW-1:0] exp_rd = '0;
    int            m_busy = 0, m_owner = -1, m_starve = 0;
    logic [2:0]    m_gnt = '0;
    bit            done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One cycle of the transaction model, evaluated after inputs settle.
    task automatic step();
        int            win;
        logic [AW-1:0] a;
        exp_t          e;
        #1;
        m_gnt = '0;
        win = -1;
        if (m_busy == 0) begin
            if (vec_req) win = 0;
            else if (mem_req && !(if_req && GUARD && m_starve >= LIM)) win = 1;
            else if (if_req) win = 2;
            if (win >= 0) begin
                m_gnt[win] = 1'b1;
                a = (win == 0) ? {{(AW-1){1'b0}}, vec_sel} : (win == 1) ? mem_addr : if_addr;
                e.owner = win;
                e.we    = (win == 1) && mem_we;
                e.drop  = 1'b0;
                e.due   = cyc + W + 1;
                e.data  = e.we ? mem_wdata : shadow[a];
                if (e.we) shadow[a] = mem_wdata;
                q.push_back(e);
                m_busy  = W;
                m_owner = win;
                chk("ram_addr", 32'(ram_addr), 32'(a));
                chk("ram_we", 32'(ram_we), 32'(e.we));
            end
            chk("ram_en_idle", 32'(ram_en), 32'(win >= 0));
        end else begin
            if (m_owner == 2 && if_flush) begin
                e = q[q.size()-1];
                e.drop = 1'b1;
                q[q.size()-1] = e;
            end
            chk("ram_en_access", 32'(ram_en), 32'd1);
            m_busy--;
        end
        if (!if_req || m_gnt[2]) m_starve = 0;
        else if (m_gnt[1] && m_starve < LIM) m_starve++;
        chk("gnt", 32'({if_gnt, mem_gnt, vec_gnt}), 32'(m_gnt));
        chk("stall", 32'({if_stall, mem_stall}), 32'({if_req && !m_gnt[2], mem_req && !m_gnt[1]}));
        @(negedge clk);
    endtask

    // mode 0: drop request on grant; 1: random traffic; 2: re-request on grant
    task automatic upd(input int mode);
        if (m_gnt[0]) vec_req = 1'b0;
        if (m_gnt[1]) begin
            if (mode == 2) mem_addr = mem_addr + 12'd1;
            else mem_req = 1'b0;
        end
        if (m_gnt[2]) begin
            if (mode == 2) if_addr = if_addr + 12'd1;
            else if_req = 1'b0;
        end
        if_flush = 1'b0;
        if (mode == 1) begin
            if (!vec_req && $urandom_range(0, 24) == 0) begin
                vec_req = 1'b1;
                vec_sel = 1'($urandom_range(0, 1));
            end
            if (!mem_req && $urandom_range(0, 2) == 0) begin
                mem_req   = 1'b1;
                mem_we    = 1'($urandom_range(0, 1));
                mem_addr  = 12'($urandom_range(0, 31));
                mem_wdata = 16'($urandom);
            end
            if (!if_req && $urandom_range(0, 1) == 0) begin
                if_req  = 1'b1;
                if_addr = 12'($urandom_range(0, 31));
            end
            if_flush = ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            step();
            upd(mode);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'({vec_gnt, mem_gnt, if_gnt}), 32'd0);
        chk({tag, "_valid"}, 32'({vec_valid, mem_valid, if_valid}), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_stall"}, 32'({mem_stall, if_stall}), 32'd0);
        chk({tag, "_ram"}, 32'({ram_en, ram_we}), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    endtask

    task automatic model_reset();
        q.delete();
        m_busy   = 0;
        m_owner  = -1;
        m_starve = 0;
        m_gnt    = '0;
        exp_rd   = '0;
    endtask

    // Monitor: pops the scoreboard on each due completion and checks valid/data
    initial begin
        exp_t       e;
        logic [2:0] ev;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && !done) begin
                ev = '0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    if (!e.drop) ev[e.owner] = 1'b1;
                    if (!e.we) exp_rd = e.data;
                    if (!e.drop) chk("rd_data", 32'(rd_data), 32'(exp_rd));
                end
                chk("valid", 32'({if_valid, mem_valid, vec_valid}), 32'(ev));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = 16'($urandom);
            shadow[i] = ram[i];
        end
        ram[0]    = 16'h0040;
        shadow[0] = 16'h0040;
        vec_req = 1'b1;
        vec_sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        run(6, 0);

        // All three requesters at once
        vec_req = 1'b1; vec_sel = 1'b1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h005;
        if_req  = 1'b1; if_addr = 12'h007;
        run(16, 0);

        // Write then fetch the same word
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 12'h123; mem_wdata = 16'hBEEF;
        if_req  = 1'b1; if_addr = 12'h123;
        run(12, 0);

        // Flush in the first access cycle, then on the completion edge
        if_req = 1'b1; if_addr = 12'h004;
        run(1, 0);
        if_flush = 1'b1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h006;
        run(9, 0);
        if_req = 1'b1; if_addr = 12'h008;
        run(W, 0);
        if_flush = 1'b1;
        run(5, 0);

        // Reset in the middle of an access
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h009;
        run(1, 0);
        if_req = 1'b1; if_addr = 12'h003;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(10, 0);

        // Continuous mem traffic against a waiting fetch
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 12'h002;
        if_req  = 1'b1; if_addr = 12'h00A;
        run(24, 2);
        mem_req = 1'b0;
        run(12, 0);

        run(3000, 1);
        vec_req = 1'b0; mem_req = 1'b0; if_req = 1'b0; if_flush = 1'b0;
        run(12, 0);
        chk("drain", 32'(q.size()), 32'd0);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
